// File: rtl/dmem_arb_pkg.sv
// Shared types and helpers for the data-memory arbiter: FSM state encoding,
// the full byte-enable constant and the read-modify-write byte merge.
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ACCESS = 2'd1,
        ST_MERGE  = 2'd2,
        ST_RESP   = 2'd3
    } state_t;

    // Upper bound on bus width; callers size-cast into and out of the merge helper.
    localparam int MAX_DATA_WIDTH = 256;
    localparam int MAX_BE_WIDTH   = MAX_DATA_WIDTH / 8;

    localparam logic [MAX_BE_WIDTH-1:0] BE_FULL = '1;

    function automatic logic [MAX_DATA_WIDTH-1:0] byte_merge(
        input logic [MAX_DATA_WIDTH-1:0] new_dat,
        input logic [MAX_DATA_WIDTH-1:0] old_dat,
        input logic [MAX_BE_WIDTH-1:0]   be
    );
        logic [MAX_DATA_WIDTH-1:0] res;
        res = old_dat;
        for (int i = 0; i < MAX_BE_WIDTH; i++) begin
            if (be[i]) res[8*i +: 8] = new_dat[8*i +: 8];
        end
        return res;
    endfunction

endpackage

// File: rtl/rr_arb2.sv
// 2-way round-robin arbiter: a lone requester always wins, a tie goes to the
// requester that did not win last. Purely combinational; grants only when enabled.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       enable,
    input  logic       last_owner,
    output logic [1:0] gnt,
    output logic       winner
);

    always_comb begin
        winner = (req == 2'b11) ? ~last_owner : req[1];
        gnt    = 2'b00;
        if (enable && (req != 2'b00)) gnt[winner] = 1'b1;
    end

endmodule

// File: rtl/dmem_arbiter.sv
// Shares the single-port data memory between two requesters (round-robin) and
// turns partial-byte stores into read-modify-write sequences; one access in flight.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 32,
    parameter int BE_WIDTH   = DATA_WIDTH / 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  r0_req,
    input  logic                  r0_we,
    input  logic [ADDR_WIDTH-1:0] r0_addr,
    input  logic [DATA_WIDTH-1:0] r0_wdata,
    input  logic [BE_WIDTH-1:0]   r0_be,
    output logic                  r0_gnt,
    output logic                  r0_rvalid,
    output logic [DATA_WIDTH-1:0] r0_rdata,
    input  logic                  r1_req,
    input  logic                  r1_we,
    input  logic [ADDR_WIDTH-1:0] r1_addr,
    input  logic [DATA_WIDTH-1:0] r1_wdata,
    input  logic [BE_WIDTH-1:0]   r1_be,
    output logic                  r1_gnt,
    output logic                  r1_rvalid,
    output logic [DATA_WIDTH-1:0] r1_rdata,
    output logic                  mem_wr_en,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic [DATA_WIDTH-1:0] mem_wr_data,
    input  logic [DATA_WIDTH-1:0] mem_rd_data,
    output logic                  busy
);

    localparam logic [ADDR_WIDTH-1:0] ADDR_MASK = ~ADDR_WIDTH'(3);

    state_t                r_state;
    state_t                w_state_nxt;
    logic                  r_last_owner;
    logic                  r_owner;
    logic                  r_we;
    logic [ADDR_WIDTH-1:0] r_addr;
    logic [DATA_WIDTH-1:0] r_wdata;
    logic [BE_WIDTH-1:0]   r_be;
    logic [DATA_WIDTH-1:0] r_rdata;
    logic [DATA_WIDTH-1:0] r_merge;

    logic [1:0]            w_gnt;
    logic                  w_winner;
    logic                  w_arb_en;
    logic                  w_be_full;
    logic                  w_resp;
    logic [DATA_WIDTH-1:0] w_merged;

    // Gating with rst_n keeps grants low while reset is held.
    assign w_arb_en = (r_state == ST_IDLE) && rst_n;

    rr_arb2 u_arb (
        .req        ({r1_req, r0_req}),
        .enable     (w_arb_en),
        .last_owner (r_last_owner),
        .gnt        (w_gnt),
        .winner     (w_winner)
    );

    assign r0_gnt    = w_gnt[0];
    assign r1_gnt    = w_gnt[1];
    assign w_be_full = (r_be == BE_FULL[BE_WIDTH-1:0]);
    assign w_merged  = DATA_WIDTH'(byte_merge(MAX_DATA_WIDTH'(r_wdata),
                                              MAX_DATA_WIDTH'(r_merge),
                                              MAX_BE_WIDTH'(r_be)));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state      <= ST_IDLE;
            r_last_owner <= 1'b1;
            r_owner      <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_be         <= '0;
            r_rdata      <= '0;
            r_merge      <= '0;
        end else begin
            r_state <= w_state_nxt;
            if (w_gnt != 2'b00) begin
                r_owner      <= w_winner;
                r_last_owner <= w_winner;
                r_we         <= w_winner ? r1_we    : r0_we;
                r_addr       <= (w_winner ? r1_addr : r0_addr) & ADDR_MASK;
                r_wdata      <= w_winner ? r1_wdata : r0_wdata;
                r_be         <= w_winner ? r1_be    : r0_be;
            end
            if (r_state == ST_ACCESS) begin
                if (!r_we) r_rdata <= mem_rd_data;
                else if (!w_be_full && (r_be != '0)) r_merge <= mem_rd_data;
            end
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        mem_wr_en   = 1'b0;
        mem_wr_data = '0;
        case (r_state)
            ST_IDLE: begin
                if (w_gnt != 2'b00) w_state_nxt = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (r_we && w_be_full) begin
                    mem_wr_en   = 1'b1;
                    mem_wr_data = r_wdata;
                    w_state_nxt = ST_RESP;
                end else if (r_we && (r_be != '0)) begin
                    w_state_nxt = ST_MERGE;
                end else begin
                    w_state_nxt = ST_RESP;
                end
            end
            ST_MERGE: begin
                mem_wr_en   = 1'b1;
                mem_wr_data = w_merged;
                w_state_nxt = ST_RESP;
            end
            ST_RESP: begin
                w_state_nxt = ST_IDLE;
            end
            default: w_state_nxt = ST_IDLE;
        endcase
    end

    assign mem_addr  = r_addr;
    assign busy      = (r_state != ST_IDLE);
    assign w_resp    = (r_state == ST_RESP);
    assign r0_rvalid = w_resp && !r_owner;
    assign r1_rvalid = w_resp && r_owner;
    // Stores complete with zero data; only a load's owner sees the captured word.
    assign r0_rdata  = (r0_rvalid && !r_we) ? r_rdata : '0;
    assign r1_rdata  = (r1_rvalid && !r_we) ? r_rdata : '0;

endmodule
